mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter DATA_W, 16, data and address width in bits (even, >=16).
REQ-002 Parameter DEPTH, 256, data memory size in DATA_W-bit words (power of two).
REQ-003 Parameter LATENCY, 2, wait cycles per memory access (>=1).
REQ-004 Parameter REG_W, 3, destination register index width.
REQ-005 clock  input  1  single clock; all state updates on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 valid_in  input  1  a stage transaction is presented.
REQ-008 MemRead, MemWrite  input  1 each  load/store request; both high is an illegal op.
REQ-009 ByteMode  input  1  access the byte at address[0] instead of the full word.
REQ-010 SignExt  input  1  sign-extend the loaded byte (otherwise zero-extend).
REQ-011 Branch, Zero  input  1 each  branch instruction flag and ALU zero flag.
REQ-012 address  input  DATA_W  byte address or ALU result.
REQ-013 writeData  input  DATA_W  store data.
REQ-014 RegDst  input  REG_W  destination register index.
REQ-015 busy  output  1  stage occupied; upstream holds its inputs.
REQ-016 valid_out  output  1  one-cycle result strobe.
REQ-017 outputMEM  output  DATA_W  load data, or address pass-through for non-memory ops.
REQ-018 RegDst_out  output  REG_W  registered RegDst.
REQ-019 PCSrc  output  1  registered branch-taken flag.
REQ-020 err  output  1  misaligned or illegal access flag.

Function
REQ-021 Accept: at cycle T when valid_in=1 and busy=0, all inputs are captured.
REQ-022 valid_in while busy=1 is ignored, not queued.
REQ-023 FSM states: IDLE, ACCESS, RESP.
- IDLE->ACCESS on accept of a legal memory op.
- IDLE->RESP on accept of a non-memory op.
REQ-024 ACCESS lasts exactly LATENCY cycles, timed by a down-counter loaded with LATENCY-1; then ACCESS->RESP.
REQ-025 RESP lasts one cycle with valid_out=1.
- RESP->IDLE, and accepting a new transaction in that same cycle is allowed (RESP->ACCESS/RESP directly).
REQ-026 busy=1 exactly while in ACCESS: memory op accepted at T gives busy high T+1..T+LATENCY and valid_out at T+LATENCY+1.
REQ-027 A non-memory op accepted at T gives valid_out at T+1, busy never high, and outputMEM=address.
REQ-028 Word index = address[log2(DEPTH):1]; upper address bits are ignored, so the index wraps modulo DEPTH.
REQ-029 A store commits at the clock edge that ends the last ACCESS cycle.
- Word store writes all bits.
- Byte store writes only the byte lane selected by address[0] (0 = low byte, 1 = high byte).
REQ-030 Word load returns the stored word.
- Byte load returns the selected byte, zero- or sign-extended to DATA_W per SignExt.
REQ-031 A load issued after a store completes to the same word returns the new data.
REQ-032 Misaligned word access (ByteMode=0, address[0]=1) or MemRead=MemWrite=1:
- skips ACCESS and commits no write;
- responds at T+1 with err=1 and outputMEM=0.
REQ-033 PCSrc = captured Branch AND Zero, valid only while valid_out=1, 0 otherwise.
REQ-034 RegDst_out and err hold their captured values while valid_out=1 and are 0 otherwise.
REQ-035 Memory contents are not cleared by reset.

Reset
REQ-036 While reset=1:
- state=IDLE, counter=0;
- busy, valid_out, PCSrc, err = 0;
- outputMEM = 0, RegDst_out = 0.
REQ-037 Reset asserted during ACCESS before the commit edge aborts the transaction: no write occurs and no valid_out is produced.
REQ-038 The first accept is possible in the first cycle after reset deasserts.

Verification
REQ-039 LATENCY=2: word store 0xBEEF @0x0010 at T -> busy high T+1..T+2; valid_out at T+3; memory word 8 = 0xBEEF.
REQ-040 Byte load of 0xBEEF, address 0x0011, SignExt=1 -> outputMEM=0xFFBE; same with SignExt=0 -> 0x00BE.
REQ-041 Byte store 0x12 @0x0010 over 0xBEEF -> word reads 0xBE12.
- Address 0x0210 with DEPTH=256 aliases word 8.
REQ-042 Word load @0x0003 -> err=1 at T+1, outputMEM=0, no busy; Branch=1, Zero=1 non-memory op -> PCSrc=1 with valid_out at T+1.
REQ-043 Back-to-back memory ops, second held during busy -> second accepted in the RESP cycle of the first; no transaction lost or duplicated.
REQ-044 Reset pulse in the second ACCESS cycle of a store -> no valid_out, target word unchanged, all outputs 0.

Source files
------------

// File: rtl/mem_stage.sv
// Memory stage: single-port data memory with a fixed access latency. Loads and stores
// go through an IDLE/ACCESS/RESP handshake; other ops pass their address straight through.
module mem_stage #(
  parameter int DATA_W  = 16,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2,
  parameter int REG_W   = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              valid_in,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              ByteMode,
  input  logic              SignExt,
  input  logic              Branch,
  input  logic              Zero,
  input  logic [DATA_W-1:0] address,
  input  logic [DATA_W-1:0] writeData,
  input  logic [REG_W-1:0]  RegDst,
  output logic              busy,
  output logic              valid_out,
  output logic [DATA_W-1:0] outputMEM,
  output logic [REG_W-1:0]  RegDst_out,
  output logic              PCSrc,
  output logic              err
);

  // state  | meaning
  // IDLE   | waiting for a transaction
  // ACCESS | memory access in progress, LATENCY cycles, busy high
  // RESP   | one-cycle result strobe; a new transaction may be accepted here
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam int AW    = $clog2(DEPTH);
  localparam int HALF  = DATA_W / 2;
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [AW-1:0]      idx_q;
  logic               lane_q;
  logic               wr_q;
  logic               byte_q;
  logic               sext_q;
  logic               br_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [REG_W-1:0]   rd_q;

  logic [DATA_W-1:0]  mem [DEPTH];

  logic               accept;
  logic               is_mem;
  logic               bad;
  logic               commit;
  logic [DATA_W-1:0]  word_rd;
  logic [HALF-1:0]    lane_rd;
  logic [DATA_W-1:0]  load_val;

  assign accept  = valid_in && (state != ACCESS);
  assign is_mem  = MemRead | MemWrite;
  assign bad     = (MemRead & MemWrite) | (is_mem & ~ByteMode & address[0]);
  assign commit  = (state == ACCESS) && (cnt == '0);
  assign word_rd = mem[idx_q];
  assign lane_rd = lane_q ? word_rd[DATA_W-1:HALF] : word_rd[HALF-1:0];

  // The "byte" lane is half a word, so address[0] alone picks it for any even DATA_W.
  always_comb begin
    load_val = word_rd;
    if (byte_q)
      load_val = {{HALF{sext_q & lane_rd[HALF-1]}}, lane_rd};
    if (wr_q)
      load_val = '0;
  end

  // Memory has no reset; an aborted access never reaches commit because reset forces IDLE.
  always_ff @(posedge clock) begin
    if (commit && wr_q) begin
      if (!byte_q)
        mem[idx_q] <= wdata_q;
      else if (lane_q)
        mem[idx_q][DATA_W-1:HALF] <= wdata_q[HALF-1:0];
      else
        mem[idx_q][HALF-1:0] <= wdata_q[HALF-1:0];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      busy       <= 1'b0;
      valid_out  <= 1'b0;
      outputMEM  <= '0;
      RegDst_out <= '0;
      PCSrc      <= 1'b0;
      err        <= 1'b0;
      idx_q      <= '0;
      lane_q     <= 1'b0;
      wr_q       <= 1'b0;
      byte_q     <= 1'b0;
      sext_q     <= 1'b0;
      br_q       <= 1'b0;
      wdata_q    <= '0;
      rd_q       <= '0;
    end else begin
      valid_out  <= 1'b0;
      outputMEM  <= '0;
      RegDst_out <= '0;
      PCSrc      <= 1'b0;
      err        <= 1'b0;
      case (state)
        ACCESS: begin
          if (cnt == '0) begin
            state      <= RESP;
            busy       <= 1'b0;
            valid_out  <= 1'b1;
            outputMEM  <= load_val;
            PCSrc      <= br_q;
            RegDst_out <= rd_q;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          if (accept) begin
            idx_q   <= address[AW:1];
            lane_q  <= address[0];
            wr_q    <= MemWrite;
            byte_q  <= ByteMode;
            sext_q  <= SignExt;
            br_q    <= Branch & Zero;
            wdata_q <= writeData;
            rd_q    <= RegDst;
            if (is_mem && !bad) begin
              state <= ACCESS;
              busy  <= 1'b1;
              cnt   <= CNT_W'(LATENCY - 1);
            end else begin
              state      <= RESP;
              valid_out  <= 1'b1;
              err        <= bad;
              outputMEM  <= bad ? '0 : address;
              PCSrc      <= Branch & Zero;
              RegDst_out <= RegDst;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios plus random ops checked against a word-array model.
module tb_mem_stage;
  localparam int DATA_W  = 16;
  localparam int DEPTH   = 256;
  localparam int LATENCY = 2;
  localparam int REG_W   = 3;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              valid_in = 1'b0;
  logic              MemRead = 1'b0, MemWrite = 1'b0, ByteMode = 1'b0, SignExt = 1'b0;
  logic              Branch = 1'b0, Zero = 1'b0;
  logic [DATA_W-1:0] address = '0, writeData = '0;
  logic [REG_W-1:0]  RegDst = '0;
  logic              busy, valid_out, PCSrc, err;
  logic [DATA_W-1:0] outputMEM;
  logic [REG_W-1:0]  RegDst_out;

  mem_stage #(.DATA_W(DATA_W), .DEPTH(DEPTH), .LATENCY(LATENCY), .REG_W(REG_W)) dut (
    .clock(clock), .reset(reset), .valid_in(valid_in), .MemRead(MemRead), .MemWrite(MemWrite),
    .ByteMode(ByteMode), .SignExt(SignExt), .Branch(Branch), .Zero(Zero), .address(address),
    .writeData(writeData), .RegDst(RegDst), .busy(busy), .valid_out(valid_out),
    .outputMEM(outputMEM), .RegDst_out(RegDst_out), .PCSrc(PCSrc), .err(err)
  );

  always #5 clock = ~clock;

  logic [15:0] mem_m [DEPTH];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] last_out;
  logic        last_err, last_pc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_vo"}, valid_out, 0);
    chk({tag, "_out"}, outputMEM, 0);
    chk({tag, "_rd"}, RegDst_out, 0);
    chk({tag, "_pc"}, PCSrc, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  task automatic drive(input logic rd, input logic wr, input logic bm, input logic se,
                       input logic br, input logic z, input logic [15:0] a,
                       input logic [15:0] wd, input logic [2:0] dst);
    valid_in = 1'b1; MemRead = rd; MemWrite = wr; ByteMode = bm; SignExt = se;
    Branch = br; Zero = z; address = a; writeData = wd; RegDst = dst;
  endtask

  // Reference: word index is (byte address / 2) mod DEPTH; byte lane = address bit 0.
  task automatic model(input logic rd, input logic wr, input logic bm, input logic se,
                       input logic [15:0] a, input logic [15:0] wd,
                       output logic is_mem, output logic e, output logic chk_out,
                       output logic [15:0] exp_out);
    int          idx;
    logic [15:0] w;
    logic [7:0]  b;
    idx     = (int'(a) / 2) % DEPTH;
    w       = mem_m[idx];
    b       = a[0] ? w[15:8] : w[7:0];
    e       = (rd && wr) || ((rd || wr) && !bm && a[0]);
    is_mem  = (rd || wr) && !e;
    chk_out = 1'b1;
    exp_out = 16'h0;
    if (e)
      exp_out = 16'h0;
    else if (!(rd || wr))
      exp_out = a;
    else if (rd)
      exp_out = !bm ? w : (se && b[7]) ? {8'hFF, b} : {8'h00, b};
    else begin
      chk_out = 1'b0;
      if (!bm)        mem_m[idx] = wd;
      else if (a[0])  mem_m[idx][15:8] = wd[7:0];
      else            mem_m[idx][7:0] = wd[7:0];
    end
  endtask

  task automatic run_op(input string tag, input logic rd, input logic wr, input logic bm,
                        input logic se, input logic br, input logic z, input logic [15:0] a,
                        input logic [15:0] wd, input logic [2:0] dst);
    logic is_mem, e, co;
    logic [15:0] eo;
    @(negedge clock);
    chk({tag, "_idle"}, busy, 0);
    model(rd, wr, bm, se, a, wd, is_mem, e, co, eo);
    drive(rd, wr, bm, se, br, z, a, wd, dst);
    @(negedge clock);
    valid_in = 1'b0;
    if (is_mem) begin
      for (int k = 1; k <= LATENCY; k++) begin
        chk({tag, "_busy"}, busy, 1);
        chk({tag, "_early_vo"}, valid_out, 0);
        @(negedge clock);
      end
    end
    chk({tag, "_vo"}, valid_out, 1);
    chk({tag, "_nbusy"}, busy, 0);
    chk({tag, "_err"}, err, e);
    chk({tag, "_pc"}, PCSrc, br & z);
    chk({tag, "_rd"}, RegDst_out, dst);
    if (co) chk({tag, "_out"}, outputMEM, eo);
    last_out = outputMEM;
    last_err = err;
    last_pc  = PCSrc;
  endtask

  initial begin
    int          vo_cnt;
    int          kind;
    logic [15:0] a;
    logic [15:0] saved;

    repeat (3) @(negedge clock);
    chk_quiet("reset");
    reset = 1'b0;

    for (int i = 0; i < DEPTH; i++)
      run_op("fill", 0, 1, 0, 0, 0, 0, 16'(i * 2), 16'($urandom), 3'(i));

    run_op("st_beef", 0, 1, 0, 0, 0, 0, 16'h0010, 16'hBEEF, 3'd1);
    run_op("ld_beef", 1, 0, 0, 0, 0, 0, 16'h0010, 16'h0, 3'd2);
    chk("word8_beef", last_out, 16'hBEEF);
    run_op("ldb_sx", 1, 0, 1, 1, 0, 0, 16'h0011, 16'h0, 3'd3);
    chk("byte_sext", last_out, 16'hFFBE);
    run_op("ldb_zx", 1, 0, 1, 0, 0, 0, 16'h0011, 16'h0, 3'd4);
    chk("byte_zext", last_out, 16'h00BE);
    run_op("stb_12", 0, 1, 1, 0, 0, 0, 16'h0010, 16'h0012, 3'd5);
    run_op("ld_alias", 1, 0, 0, 0, 0, 0, 16'h0210, 16'h0, 3'd6);
    chk("alias_be12", last_out, 16'hBE12);
    run_op("misalign", 1, 0, 0, 0, 0, 0, 16'h0003, 16'h0, 3'd7);
    chk("misalign_err", last_err, 1);
    run_op("branch", 0, 0, 0, 0, 1, 1, 16'h1234, 16'h0, 3'd2);
    chk("branch_pc", last_pc, 1);
    run_op("illegal", 1, 1, 0, 0, 0, 0, 16'h0020, 16'h5555, 3'd1);

    // Back-to-back: store then load of the same word, the load held while busy.
    @(negedge clock);
    begin
      logic im, e, co; logic [15:0] eo;
      model(0, 1, 0, 0, 16'h0020, 16'hCAFE, im, e, co, eo);
    end
    drive(0, 1, 0, 0, 0, 0, 16'h0020, 16'hCAFE, 3'd3);
    vo_cnt = 0;
    for (int c = 1; c <= 2 * LATENCY + 4; c++) begin
      @(negedge clock);
      if (valid_out) vo_cnt++;
      if (c == LATENCY + 1) chk("b2b_a_vo", valid_out, 1);
      if (c == 2 * LATENCY + 2) begin
        chk("b2b_b_vo", valid_out, 1);
        chk("b2b_b_out", outputMEM, 16'hCAFE);
        chk("b2b_b_rd", RegDst_out, 3'd4);
      end
      if (c == 1) drive(1, 0, 0, 0, 0, 0, 16'h0020, 16'h0, 3'd4);
      if (c == LATENCY + 2) valid_in = 1'b0;
    end
    chk("b2b_count", vo_cnt, 2);

    // Reset in the second ACCESS cycle of a store aborts it.
    saved = mem_m[8];
    @(negedge clock);
    drive(0, 1, 0, 0, 0, 0, 16'h0010, 16'h5A5A, 3'd5);
    @(negedge clock);
    valid_in = 1'b0;
    chk("abort_busy1", busy, 1);
    @(negedge clock);
    chk("abort_busy2", busy, 1);
    reset = 1'b1;
    #1;
    chk_quiet("abort_rst");
    @(negedge clock);
    reset = 1'b0;
    vo_cnt = 0;
    repeat (4) begin
      @(negedge clock);
      if (valid_out) vo_cnt++;
    end
    chk("abort_no_vo", vo_cnt, 0);
    run_op("abort_ld", 1, 0, 0, 0, 0, 0, 16'h0010, 16'h0, 3'd0);
    chk("abort_kept", last_out, saved);

    for (int n = 0; n < 300; n++) begin
      kind = int'($urandom_range(0, 5));
      a    = 16'($urandom);
      if (kind <= 1 && $urandom_range(0, 3) != 0) a[0] = 1'b0;
      case (kind)
        0: run_op("r_ldw", 1, 0, 0, 0, 1'($urandom), 1'($urandom), a, 16'h0, 3'($urandom));
        1: run_op("r_stw", 0, 1, 0, 0, 1'($urandom), 1'($urandom), a, 16'($urandom), 3'($urandom));
        2: run_op("r_ldb", 1, 0, 1, 1'($urandom), 1'($urandom), 1'($urandom), a, 16'h0, 3'($urandom));
        3: run_op("r_stb", 0, 1, 1, 0, 1'($urandom), 1'($urandom), a, 16'($urandom), 3'($urandom));
        4: run_op("r_alu", 0, 0, 1'($urandom), 0, 1'($urandom), 1'($urandom), a, 16'($urandom), 3'($urandom));
        default: run_op("r_ill", 1, 1, 1'($urandom), 0, 1'($urandom), 1'($urandom), a, 16'($urandom), 3'($urandom));
      endcase
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
